// File: rtl/seq_entry_buffer.sv
// seq_entry_buffer: operator digit-entry history for the 8-digit display.
// BTN_0 strobes (PUSH) capture the switch nibble as the newest digit
// (rightmost, digit 0); BTN_1 strobes (POP) act as backspace.
// All outputs are registered, so a strobe shows on the following edge.
//
// Optional feature, enabled by defining SEQ_ENTRY_IDLE_CLEAR_EN:
// an idle timer counts CE_1KHZ ticks while the buffer is non-empty and
// clears the buffer after IDLE_MS ticks without operator activity.
// With the macro undefined, no counter exists and CE_1KHZ is ignored.
module seq_entry_buffer #(
  parameter int DEPTH    = 8,     // display width; only 8 is supported
  parameter int IDLE_MS  = 5000,  // idle timeout in CE_1KHZ ticks
  parameter int IDLE_WDT = 13     // idle counter width, 2**IDLE_WDT > IDLE_MS
) (
  input  logic        CLK_48,
  input  logic        SYS_NRST,
  input  logic        CE_1KHZ,
  input  logic        PUSH,
  input  logic        POP,
  input  logic        CLR,
  input  logic [3:0]  DAT_I,
  output logic [31:0] HEX_OUT,
  output logic [7:0]  BLANK_OUT,
  output logic [3:0]  COUNT,
  output logic        EMPTY,
  output logic        FULL,
  output logic        OVF,
  output logic [3:0]  LAST_O,
  output logic        LAST_VLD
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  // Blank mask for a fill level: digit i is dark when i >= cnt.
  function automatic logic [7:0] blank_of(input logic [3:0] cnt);
    logic [7:0] mask;
    mask = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mask[i] = (4'(i) >= cnt);
    end
    return mask;
  endfunction

  state_t      state_r, state_s;
  logic [31:0] hex_r, hex_s;
  logic [3:0]  count_r, count_s;
  logic [7:0]  blank_r;
  logic        empty_r, full_r;
  logic        ovf_r, ovf_s;
  logic [3:0]  last_r, last_s;
  logic        last_vld_r, last_vld_s;
  logic        accept_s;     // a PUSH/POP/CLR that actually changed the buffer
  logic        idle_fire_s;  // internal clear request from the idle timer
  logic        clr_s;

  assign clr_s = CLR | idle_fire_s;

`ifdef SEQ_ENTRY_IDLE_CLEAR_EN
  localparam logic [IDLE_WDT-1:0] IDLE_LIM = IDLE_WDT'(IDLE_MS);

  logic [IDLE_WDT-1:0] idle_cnt_r, idle_cnt_s;

  // The timer reached its limit on the previous tick: clear on this edge.
  assign idle_fire_s = (state_r != S_EMPTY) && (idle_cnt_r == IDLE_LIM);

  // Idle counter: restart on activity, hold at zero while empty, saturate at the limit.
  always_comb begin
    idle_cnt_s = idle_cnt_r;
    if (accept_s) begin
      idle_cnt_s = {IDLE_WDT{1'b0}};
    end else if (state_r == S_EMPTY) begin
      idle_cnt_s = {IDLE_WDT{1'b0}};
    end else if (CE_1KHZ && (idle_cnt_r != IDLE_LIM)) begin
      idle_cnt_s = idle_cnt_r + IDLE_WDT'(1);
    end else begin
      idle_cnt_s = idle_cnt_r;
    end
  end

  // Idle counter register.
  always_ff @(posedge CLK_48 or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      idle_cnt_r <= {IDLE_WDT{1'b0}};
    end else begin
      idle_cnt_r <= idle_cnt_s;
    end
  end
`else
  logic unused_idle_s;

  assign idle_fire_s   = 1'b0;
  assign unused_idle_s = CE_1KHZ;
`endif

  // Next-state logic; priority is clear, then replace, then push, then pop.
  always_comb begin
    state_s    = state_r;
    hex_s      = hex_r;
    count_s    = count_r;
    ovf_s      = 1'b0;
    last_s     = last_r;
    last_vld_s = 1'b0;
    accept_s   = 1'b0;
    if (clr_s) begin
      // LAST_O is deliberately kept across a clear.
      state_s  = S_EMPTY;
      hex_s    = 32'h0000_0000;
      count_s  = 4'd0;
      accept_s = 1'b1;
    end else if (PUSH && POP) begin
      // Replace newest digit; an empty buffer treats it as a plain push.
      last_s     = DAT_I;
      last_vld_s = 1'b1;
      accept_s   = 1'b1;
      if (state_r == S_EMPTY) begin
        hex_s   = {28'h000_0000, DAT_I};
        count_s = 4'd1;
        state_s = S_PART;
      end else begin
        hex_s = {hex_r[31:4], DAT_I};
      end
    end else if (PUSH) begin
      hex_s      = {hex_r[27:0], DAT_I};
      last_s     = DAT_I;
      last_vld_s = 1'b1;
      accept_s   = 1'b1;
      case (state_r)
        S_EMPTY: begin
          count_s = 4'd1;
          state_s = S_PART;
        end
        S_PART: begin
          count_s = count_r + 4'd1;
          if (count_r == 4'd7) begin
            state_s = S_FULL;
          end else begin
            state_s = S_PART;
          end
        end
        S_FULL: begin
          // Oldest digit falls off the left end; fill level stays at 8.
          ovf_s = 1'b1;
        end
        default: begin
          state_s    = S_EMPTY;
          hex_s      = 32'h0000_0000;
          count_s    = 4'd0;
          last_vld_s = 1'b0;
        end
      endcase
    end else if (POP) begin
      case (state_r)
        S_EMPTY: begin
          // Backspace on an empty buffer is ignored entirely.
          accept_s = 1'b0;
        end
        S_PART: begin
          hex_s    = {4'h0, hex_r[31:4]};
          count_s  = count_r - 4'd1;
          accept_s = 1'b1;
          if (count_r == 4'd1) begin
            state_s = S_EMPTY;
          end else begin
            state_s = S_PART;
          end
        end
        S_FULL: begin
          hex_s    = {4'h0, hex_r[31:4]};
          count_s  = 4'd7;
          accept_s = 1'b1;
          state_s  = S_PART;
        end
        default: begin
          state_s = S_EMPTY;
          hex_s   = 32'h0000_0000;
          count_s = 4'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers; flags and blank mask track the next fill level.
  always_ff @(posedge CLK_48 or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      state_r    <= S_EMPTY;
      hex_r      <= 32'h0000_0000;
      count_r    <= 4'd0;
      blank_r    <= 8'hFF;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      ovf_r      <= 1'b0;
      last_r     <= 4'h0;
      last_vld_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      hex_r      <= hex_s;
      count_r    <= count_s;
      blank_r    <= blank_of(count_s);
      empty_r    <= (count_s == 4'd0);
      full_r     <= (count_s == 4'd8);
      ovf_r      <= ovf_s;
      last_r     <= last_s;
      last_vld_r <= last_vld_s;
    end
  end

  assign HEX_OUT   = hex_r;
  assign BLANK_OUT = blank_r;
  assign COUNT     = count_r;
  assign EMPTY     = empty_r;
  assign FULL      = full_r;
  assign OVF       = ovf_r;
  assign LAST_O    = last_r;
  assign LAST_VLD  = last_vld_r;

endmodule

// File: tb/tb_seq_entry_buffer.sv
// Self-checking bench for seq_entry_buffer. A digit-list model predicts the
// outputs of every strobe cycle; predictions are queued when the stimulus is
// driven and compared after the clock edge. Scenario tasks add directed checks.
module tb_seq_entry_buffer;

  logic        clk = 1'b0;
  logic        sys_nrst;
  logic        ce;
  logic        push;
  logic        pop;
  logic        clr;
  logic [3:0]  dat;
  logic [31:0] hex_o;
  logic [7:0]  blank_o;
  logic [3:0]  count_o;
  logic        empty_o;
  logic        full_o;
  logic        ovf_o;
  logic [3:0]  last_o;
  logic        last_vld_o;

  typedef struct packed {
    logic [31:0] hex;
    logic [7:0]  blank;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        ovf;
    logic [3:0]  last;
    logic        last_vld;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] m_digits[$];   // model contents, index 0 = newest
  logic [3:0] m_last;
  int         n_tests = 0;
  int         n_fail  = 0;

  localparam exp_t RST_E = '{hex: 32'h0, blank: 8'hFF, count: 4'd0, empty: 1'b1,
                             full: 1'b0, ovf: 1'b0, last: 4'h0, last_vld: 1'b0};

  seq_entry_buffer #(.DEPTH(8), .IDLE_MS(10), .IDLE_WDT(13)) dut (
    .CLK_48   (clk),
    .SYS_NRST (sys_nrst),
    .CE_1KHZ  (ce),
    .PUSH     (push),
    .POP      (pop),
    .CLR      (clr),
    .DAT_I    (dat),
    .HEX_OUT  (hex_o),
    .BLANK_OUT(blank_o),
    .COUNT    (count_o),
    .EMPTY    (empty_o),
    .FULL     (full_o),
    .OVF      (ovf_o),
    .LAST_O   (last_o),
    .LAST_VLD (last_vld_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t snapshot(input logic ovf, input logic lvld);
    exp_t e;
    e.hex = 32'h0;
    for (int i = 0; i < m_digits.size(); i++) begin
      e.hex = e.hex | (32'(m_digits[i]) << (4 * i));
    end
    for (int i = 0; i < 8; i++) begin
      e.blank[i] = (i >= m_digits.size());
    end
    e.count    = 4'(m_digits.size());
    e.empty    = (m_digits.size() == 0);
    e.full     = (m_digits.size() == 8);
    e.ovf      = ovf;
    e.last     = m_last;
    e.last_vld = lvld;
    return e;
  endfunction

  function automatic exp_t got_now();
    exp_t g;
    g = {hex_o, blank_o, count_o, empty_o, full_o, ovf_o, last_o, last_vld_o};
    return g;
  endfunction

  // One strobe cycle: drive, predict, queue; then pop the prediction and compare.
  task automatic step(input logic p, input logic o, input logic c, input logic [3:0] d);
    logic ovf_e;
    logic lv_e;
    exp_t e;
    exp_t g;
    @(negedge clk);
    push = p; pop = o; clr = c; dat = d; ce = 1'b0;
    ovf_e = 1'b0;
    lv_e  = 1'b0;
    if (c) begin
      m_digits.delete();
    end else if (p && o) begin
      if (m_digits.size() == 0) m_digits.push_front(d);
      else m_digits[0] = d;
      m_last = d;
      lv_e   = 1'b1;
    end else if (p) begin
      if (m_digits.size() == 8) begin
        void'(m_digits.pop_back());
        ovf_e = 1'b1;
      end
      m_digits.push_front(d);
      m_last = d;
      lv_e   = 1'b1;
    end else if (o) begin
      if (m_digits.size() > 0) void'(m_digits.pop_front());
    end
    exp_q.push_back(snapshot(ovf_e, lv_e));
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr = 1'b0;
    e = exp_q.pop_front();
    g = got_now();
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL step(push=%0b pop=%0b clr=%0b dat=%h): got hex=%h blank=%h cnt=%0d e=%0b f=%0b ovf=%0b last=%h lv=%0b, required hex=%h blank=%h cnt=%0d e=%0b f=%0b ovf=%0b last=%h lv=%0b",
               p, o, c, d, g.hex, g.blank, g.count, g.empty, g.full, g.ovf, g.last, g.last_vld,
               e.hex, e.blank, e.count, e.empty, e.full, e.ovf, e.last, e.last_vld);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ce = 1'b1;
      @(posedge clk);
      #1;
      ce = 1'b0;
    end
  endtask

  task automatic test_reset();
    exp_t g;
    sys_nrst = 1'b0; ce = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0; dat = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    g = got_now();
    n_tests++;
    if (g !== RST_E) begin
      n_fail++;
      $display("FAIL reset_values: got %h, required %h", g, RST_E);
    end
    @(negedge clk);
    sys_nrst = 1'b1;
    m_digits.delete();
    m_last = 4'h0;
    step(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_push_abc();
    step(1'b1, 1'b0, 1'b0, 4'hA);
    step(1'b1, 1'b0, 1'b0, 4'hB);
    step(1'b1, 1'b0, 1'b0, 4'hC);
    n_tests++;
    if (hex_o !== 32'h00000ABC || count_o !== 4'd3 || blank_o !== 8'hF8 || last_o !== 4'hC) begin
      n_fail++;
      $display("FAIL push_abc: got hex=%h cnt=%0d blank=%h last=%h, required 00000abc 3 f8 c",
               hex_o, count_o, blank_o, last_o);
    end
  endtask

  task automatic test_pop();
    step(1'b0, 1'b1, 1'b0, 4'h0);
    n_tests++;
    if (hex_o !== 32'h000000AB || count_o !== 4'd2 || blank_o !== 8'hFC) begin
      n_fail++;
      $display("FAIL pop_1: got hex=%h cnt=%0d blank=%h, required 000000ab 2 fc", hex_o, count_o, blank_o);
    end
    step(1'b0, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 4'h0);
    n_tests++;
    if (empty_o !== 1'b1 || blank_o !== 8'hFF || hex_o !== 32'h0) begin
      n_fail++;
      $display("FAIL pop_3: got empty=%0b blank=%h hex=%h, required 1 ff 0", empty_o, blank_o, hex_o);
    end
    step(1'b0, 1'b1, 1'b0, 4'h0);
    n_tests++;
    if (count_o !== 4'd0 || last_vld_o !== 1'b0 || ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pop_empty: got cnt=%0d lv=%0b ovf=%0b, required 0 0 0", count_o, last_vld_o, ovf_o);
    end
  endtask

  task automatic test_replace();
    step(1'b1, 1'b0, 1'b0, 4'hA);
    step(1'b1, 1'b0, 1'b0, 4'hB);
    step(1'b1, 1'b0, 1'b0, 4'hC);
    step(1'b1, 1'b1, 1'b0, 4'hE);
    n_tests++;
    if (hex_o !== 32'h00000ABE || count_o !== 4'd3 || ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL replace: got hex=%h cnt=%0d ovf=%0b, required 00000abe 3 0", hex_o, count_o, ovf_o);
    end
    step(1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b1, 1'b1, 1'b0, 4'hE);
    n_tests++;
    if (hex_o !== 32'h0000000E || count_o !== 4'd1) begin
      n_fail++;
      $display("FAIL replace_empty: got hex=%h cnt=%0d, required 0000000e 1", hex_o, count_o);
    end
  endtask

  task automatic test_overflow();
    step(1'b0, 1'b0, 1'b1, 4'h0);
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 4'(i));
    n_tests++;
    if (full_o !== 1'b1 || hex_o !== 32'h12345678 || ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_8: got full=%0b hex=%h ovf=%0b, required 1 12345678 0", full_o, hex_o, ovf_o);
    end
    step(1'b1, 1'b0, 1'b0, 4'h9);
    n_tests++;
    if (hex_o !== 32'h23456789 || count_o !== 4'd8 || ovf_o !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: got hex=%h cnt=%0d ovf=%0b, required 23456789 8 1", hex_o, count_o, ovf_o);
    end
    step(1'b0, 1'b0, 1'b0, 4'h0);
    n_tests++;
    if (ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_pulse: got ovf=%0b, required 0", ovf_o);
    end
    step(1'b1, 1'b1, 1'b0, 4'h1);
    step(1'b0, 1'b1, 1'b0, 4'h0);
    n_tests++;
    if (count_o !== 4'd7 || full_o !== 1'b0 || hex_o !== 32'h02345678) begin
      n_fail++;
      $display("FAIL pop_full: got cnt=%0d full=%0b hex=%h, required 7 0 02345678", count_o, full_o, hex_o);
    end
  endtask

  task automatic test_clr_reset();
    exp_t g;
    step(1'b1, 1'b0, 1'b1, 4'h5);
    n_tests++;
    if (count_o !== 4'd0 || hex_o !== 32'h0 || last_o !== 4'h1) begin
      n_fail++;
      $display("FAIL clr_push: got cnt=%0d hex=%h last=%h, required 0 0 1", count_o, hex_o, last_o);
    end
    step(1'b1, 1'b0, 1'b0, 4'h7);
    step(1'b1, 1'b0, 1'b0, 4'h3);
    @(negedge clk);
    #2;
    sys_nrst = 1'b0;
    #1;
    g = got_now();
    n_tests++;
    if (g !== RST_E) begin
      n_fail++;
      $display("FAIL async_reset: got %h, required %h", g, RST_E);
    end
    #1;
    sys_nrst = 1'b1;
    m_digits.delete();
    m_last = 4'h0;
    step(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_idle();
    step(1'b1, 1'b0, 1'b0, 4'h6);
`ifdef SEQ_ENTRY_IDLE_CLEAR_EN
    tick(9);
    n_tests++;
    if (count_o !== 4'd1) begin
      n_fail++;
      $display("FAIL idle_tick9: got cnt=%0d, required 1", count_o);
    end
    step(1'b1, 1'b0, 1'b0, 4'h8);
    tick(9);
    n_tests++;
    if (count_o !== 4'd2 || hex_o !== 32'h00000068) begin
      n_fail++;
      $display("FAIL idle_restart: got cnt=%0d hex=%h, required 2 00000068", count_o, hex_o);
    end
    tick(1);
    @(posedge clk);
    #1;
    n_tests++;
    if (count_o !== 4'd0 || empty_o !== 1'b1 || hex_o !== 32'h0 || blank_o !== 8'hFF ||
        last_vld_o !== 1'b0 || ovf_o !== 1'b0 || last_o !== 4'h8) begin
      n_fail++;
      $display("FAIL idle_clear: got cnt=%0d empty=%0b hex=%h blank=%h lv=%0b ovf=%0b last=%h, required 0 1 0 ff 0 0 8",
               count_o, empty_o, hex_o, blank_o, last_vld_o, ovf_o, last_o);
    end
    step(1'b0, 1'b0, 1'b1, 4'h0);
`else
    tick(10000);
    n_tests++;
    if (count_o !== 4'd1 || hex_o !== 32'h00000006) begin
      n_fail++;
      $display("FAIL idle_disabled: got cnt=%0d hex=%h, required 1 00000006", count_o, hex_o);
    end
    step(1'b0, 1'b0, 1'b0, 4'h0);
`endif
  endtask

  initial begin
    test_reset();
    test_push_abc();
    test_pop();
    test_replace();
    test_overflow();
    test_clr_reset();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_entry_buffer.md
Name: seq_entry_buffer

Overview:
- Operator-entry stage between the button filters/switch synchroniser and the 7-segment driver.
- Each filtered BTN_0 strobe captures the 4-bit switch value into an 8-digit history, newest digit rightmost.
- Each BTN_1 strobe deletes the newest digit (backspace).
- Drives the HEX_IN/BLANK inputs of the LED driver; also reports fill level and the most recently accepted nibble.

Parameters:
- DEPTH, 8, number of stored nibbles; fixed by the 8-digit display; only 8 is supported.
- IDLE_MS, 5000, idle timeout in CE_1KHZ ticks; used only with IDLE_CLEAR_EN.
- IDLE_WDT, 13, width of the idle counter; must satisfy 2^IDLE_WDT > IDLE_MS.

Ports:
- CLK_48  in  1  system clock; all logic on its rising edge.
- SYS_NRST  in  1  asynchronous active-low reset.
- CE_1KHZ  in  1  one-cycle 1 kHz tick; used only by the idle timer.
- PUSH  in  1  one-cycle strobe from button filter 0; captures DAT_I.
- POP  in  1  one-cycle strobe from button filter 1; deletes newest entry.
- CLR  in  1  synchronous clear strobe.
- DAT_I  in  4  synchronised switch nibble.
- HEX_OUT  out  32  display data; digit i = HEX_OUT[4i+3:4i]; digit 0 = newest.
- BLANK_OUT  out  8  1 = digit dark; bit i set when i >= COUNT.
- COUNT  out  4  number of valid entries, 0..8.
- EMPTY  out  1  COUNT == 0.
- FULL  out  1  COUNT == 8.
- OVF  out  1  one-cycle pulse when a push discards the oldest entry.
- LAST_O  out  4  most recently pushed nibble.
- LAST_VLD  out  1  one-cycle pulse, the cycle after an accepted push.

Behaviour:
- Reset (asynchronous, SYS_NRST=0) values:
  - HEX_OUT=0, BLANK_OUT=8'hFF, COUNT=0, EMPTY=1, FULL=0.
  - OVF=0, LAST_O=0, LAST_VLD=0; idle counter=0; FSM=S_EMPTY.
- Reset release is synchronous to CLK_48 from the upstream synchroniser; no extra sync inside.
- All outputs are registered. Effect of a strobe is visible on the first CLK_48 edge after it: 1-cycle latency.
- FSM states S_EMPTY, S_PART, S_FULL. Per-cycle priority: CLR > (PUSH&POP) > PUSH > POP.
- CLR from any state -> S_EMPTY:
  - HEX_OUT=0, COUNT=0, BLANK_OUT=FF, idle counter=0.
  - LAST_O is kept.
- PUSH only:
  - HEX_OUT <= {HEX_OUT[27:0], DAT_I}; LAST_O <= DAT_I; LAST_VLD=1.
  - S_EMPTY -> S_PART, COUNT=1.
  - S_PART: COUNT+1; at COUNT reaching 8 -> S_FULL.
  - S_FULL: oldest digit (HEX_OUT[31:28]) is discarded, COUNT stays 8, OVF=1 for one cycle.
- POP only:
  - HEX_OUT <= {4'h0, HEX_OUT[31:4]}; COUNT-1.
  - S_FULL -> S_PART; S_PART with COUNT=1 -> S_EMPTY.
  - POP in S_EMPTY is ignored: no change, no pulse.
- PUSH and POP in the same cycle (replace newest):
  - HEX_OUT[3:0] <= DAT_I; COUNT unchanged; LAST_O/LAST_VLD as for a push.
  - In S_EMPTY this acts as a plain push.
  - OVF is never raised on a replace.
- Invariants:
  - BLANK_OUT = ~((1<<COUNT)-1), registered together with COUNT.
  - Digits at positions >= COUNT always hold 0.
- Strobes wider than one cycle are acted on every cycle they are high. The upstream filter guarantees single-cycle strobes.
- Idle counter: cleared by any accepted PUSH, POP or CLR.

Optional Feature:
- Macro: SEQ_ENTRY_IDLE_CLEAR_EN.
- Defined:
  - Idle counter increments on CE_1KHZ while COUNT != 0, saturating at IDLE_MS.
  - On the CE_1KHZ tick that brings it to IDLE_MS, the buffer performs an internal CLR on the next edge.
  - That clear has the same effect as the CLR port; OVF and LAST_VLD are not pulsed.
  - The counter is held at 0 in S_EMPTY.
- Not defined:
  - No counter is synthesised; CE_1KHZ is unused.
  - Contents persist until CLR, POP or reset.

Test Plan:
- Reset then push A,B,C (one strobe each, DAT_I=4'hA/B/C) -> HEX_OUT=32'h00000ABC, COUNT=3, BLANK_OUT=8'hF8, LAST_O=C, LAST_VLD pulses 3 times.
- Push 1..9 (9 pushes) -> after 8th: FULL=1, HEX_OUT=32'h12345678; after 9th: HEX_OUT=32'h23456789, COUNT=8, OVF single pulse.
- From 32'h00000ABC: POP x4 -> after POP 1: 32'h000000AB, COUNT=2, BLANK_OUT=8'hFC; after POP 3: EMPTY=1, BLANK_OUT=8'hFF; 4th POP makes no change.
- PUSH&POP together with DAT_I=4'hE on 32'h00000ABC -> 32'h00000ABE, COUNT=3, no OVF; same stimulus when empty -> 32'h0000000E, COUNT=1.
- CLR asserted together with PUSH, and SYS_NRST pulsed low mid-entry without a clock edge -> CLR wins (COUNT=0); async reset clears all outputs immediately to reset values.
- With SEQ_ENTRY_IDLE_CLEAR_EN, IDLE_MS=10: push one digit, give 10 CE_1KHZ ticks -> buffer empty after 10th tick. A push at tick 9 restarts the count; without the macro the buffer is unchanged after 10000 ticks.
